wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/wb_fwd_match.sv | 39 +++
 rtl/wb_queue.sv | 129 ++++++++++++
 tb/tb_wb_queue.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
//==============================================================================
// Module : cpu_pkg
// Desc   : Shared CPU widths and the write-back queue entry type.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam int N_DEFAULT     = 32;
    localparam int NADDR_DEFAULT = 5;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [NADDR_DEFAULT-1:0] addr;
        logic [N_DEFAULT-1:0]     data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fwd_match.sv
//==============================================================================
// Module : wb_fwd_match
// Desc   : Finds the newest valid queue entry whose address matches a lookup.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wb_fwd_match
    import cpu_pkg::*;
#(
    parameter int n     = N_DEFAULT,
    parameter int naddr = NADDR_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH*naddr-1:0]   addr_vec,
    input  logic [DEPTH*n-1:0]       data_vec,
    input  logic [$clog2(DEPTH)-1:0] oldest,
    input  logic [naddr-1:0]         lookup,
    output logic                     hit,
    output logic [n-1:0]             data
);

    // Walk oldest to newest so the last match written is the newest one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[(int'(oldest) + i) % DEPTH] && (lookup != '0) &&
                (addr_vec[((int'(oldest) + i) % DEPTH) * naddr +: naddr] == lookup)) begin
                hit  = 1'b1;
                data = data_vec[((int'(oldest) + i) % DEPTH) * n +: n];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_queue.sv
//==============================================================================
// Module : wb_queue
// Desc   : Write-back FIFO in front of the register-file write port; optional
//          forwarding from queued entries when WB_QUEUE_BYPASS_EN is defined.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wb_queue
    import cpu_pkg::*;
#(
    parameter int n     = N_DEFAULT,
    parameter int naddr = NADDR_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [naddr-1:0]       in_addr,
    input  logic [n-1:0]           in_data,
    input  logic                   drain_en,
    output logic                   wrEn,
    output logic [naddr-1:0]       wd_addr,
    output logic [n-1:0]           wd,
    input  logic [naddr-1:0]       ra_addr,
    input  logic [naddr-1:0]       rb_addr,
    output logic                   fwd_a_hit,
    output logic                   fwd_b_hit,
    output logic [n-1:0]           fwd_a,
    output logic [n-1:0]           fwd_b,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [DEPTH-1:0]   r_valid;
    logic [naddr-1:0]   r_mem_addr [DEPTH];
    logic [n-1:0]       r_mem_data [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == c_cnt_w'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    // $zero writes are handshaken but never stored.
    assign w_push   = in_valid && in_ready && (in_addr != '0);
    assign w_pop    = drain_en && !w_empty;

    assign wrEn    = w_pop;
    assign wd_addr = w_empty ? '0 : r_mem_addr[r_head];
    assign wd      = w_empty ? '0 : r_mem_data[r_head];
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            // Push and pop never share a slot: that needs empty-and-pop or full-and-push.
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_addr[r_tail] <= in_addr;
            r_mem_data[r_tail] <= in_data;
        end
    end

`ifdef WB_QUEUE_BYPASS_EN
    logic [DEPTH*naddr-1:0] w_addr_vec;
    logic [DEPTH*n-1:0]     w_data_vec;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
        assign w_addr_vec[gi*naddr +: naddr] = r_mem_addr[gi];
        assign w_data_vec[gi*n +: n]         = r_mem_data[gi];
    end

    wb_fwd_match #(.n(n), .naddr(naddr), .DEPTH(DEPTH)) u_fwd_a (
        .valid    (r_valid),
        .addr_vec (w_addr_vec),
        .data_vec (w_data_vec),
        .oldest   (r_head),
        .lookup   (ra_addr),
        .hit      (fwd_a_hit),
        .data     (fwd_a)
    );

    wb_fwd_match #(.n(n), .naddr(naddr), .DEPTH(DEPTH)) u_fwd_b (
        .valid    (r_valid),
        .addr_vec (w_addr_vec),
        .data_vec (w_data_vec),
        .oldest   (r_head),
        .lookup   (rb_addr),
        .hit      (fwd_b_hit),
        .data     (fwd_b)
    );
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{ra_addr, rb_addr, r_valid};

    assign fwd_a_hit = 1'b0;
    assign fwd_b_hit = 1'b0;
    assign fwd_a     = '0;
    assign fwd_b     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_queue.sv
//==============================================================================
// Module : tb_wb_queue
// Desc   : Directed self-checking bench for wb_queue.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_wb_queue;
    import cpu_pkg::*;

`ifdef WB_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_en;
    logic        wrEn;
    logic [4:0]  wd_addr;
    logic [31:0] wd;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    wb_queue dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .drain_en  (drain_en),
        .wrEn      (wrEn),
        .wd_addr   (wd_addr),
        .wd        (wd),
        .ra_addr   (ra_addr),
        .rb_addr   (rb_addr),
        .fwd_a_hit (fwd_a_hit),
        .fwd_b_hit (fwd_b_hit),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drain_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %0b want 1", in_ready); n_err++; end
        n_cmp++;
        if (wrEn !== 1'b0) begin $display("FAIL rst_wrEn: got %0b want 0", wrEn); n_err++; end
        n_cmp++;
        if (wd_addr !== 5'd0) begin $display("FAIL rst_wd_addr: got %0d want 0", wd_addr); n_err++; end
        n_cmp++;
        if (wd !== 32'd0) begin $display("FAIL rst_wd: got %h want 0", wd); n_err++; end
        n_cmp++;
        if (count !== 3'd0) begin $display("FAIL rst_count: got %0d want 0", count); n_err++; end
        n_cmp++;
        if ({fwd_a_hit, fwd_b_hit} !== 2'b00) begin $display("FAIL rst_hits: got %b want 00", {fwd_a_hit, fwd_b_hit}); n_err++; end
        n_cmp++;
        if ({fwd_a, fwd_b} !== 64'd0) begin $display("FAIL rst_fwd: got %h want 0", {fwd_a, fwd_b}); n_err++; end
        n_cmp++;
        drain_en = 1'b0;
        tick();
    endtask

    task automatic test_single();
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_addr  = 5'd3;
        in_data  = 32'hDEADBEEF;
        #1;
        if (wrEn !== 1'b0) begin $display("FAIL single_same_cycle: got %0b want 0", wrEn); n_err++; end
        n_cmp++;
        tick();
        in_valid = 1'b0;
        #1;
        if (wrEn !== 1'b1) begin $display("FAIL single_wrEn: got %0b want 1", wrEn); n_err++; end
        n_cmp++;
        if (wd_addr !== 5'd3) begin $display("FAIL single_wd_addr: got %0d want 3", wd_addr); n_err++; end
        n_cmp++;
        if (wd !== 32'hDEADBEEF) begin $display("FAIL single_wd: got %h want deadbeef", wd); n_err++; end
        n_cmp++;
        if (count !== 3'd1) begin $display("FAIL single_count1: got %0d want 1", count); n_err++; end
        n_cmp++;
        tick();
        if (count !== 3'd0) begin $display("FAIL single_count0: got %0d want 0", count); n_err++; end
        n_cmp++;
        if (wrEn !== 1'b0) begin $display("FAIL single_idle: got %0b want 0", wrEn); n_err++; end
        n_cmp++;
        drain_en = 1'b0;
    endtask

    task automatic test_fill();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) push(5'(i + 1), 32'hA0 + 32'(i));
        in_valid = 1'b1;
        in_addr  = 5'd5;
        in_data  = 32'hFF;
        #1;
        if (count !== 3'd4) begin $display("FAIL fill_count: got %0d want 4", count); n_err++; end
        n_cmp++;
        if (in_ready !== 1'b0) begin $display("FAIL fill_in_ready: got %0b want 0", in_ready); n_err++; end
        n_cmp++;
        tick();
        in_valid = 1'b0;
        if (count !== 3'd4) begin $display("FAIL fill_fifth_rejected: got %0d want 4", count); n_err++; end
        n_cmp++;
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (wrEn !== 1'b1) begin $display("FAIL fill_drain_wrEn[%0d]: got %0b want 1", i, wrEn); n_err++; end
            n_cmp++;
            if (wd_addr !== 5'(i + 1)) begin $display("FAIL fill_drain_addr[%0d]: got %0d want %0d", i, wd_addr, i + 1); n_err++; end
            n_cmp++;
            if (wd !== 32'hA0 + 32'(i)) begin $display("FAIL fill_drain_data[%0d]: got %h want %h", i, wd, 32'hA0 + 32'(i)); n_err++; end
            n_cmp++;
            if (i == 1) begin
                if (in_ready !== 1'b1) begin $display("FAIL fill_ready_after_pop: got %0b want 1", in_ready); n_err++; end
                n_cmp++;
            end
            tick();
        end
        #1;
        if (count !== 3'd0) begin $display("FAIL fill_empty: got %0d want 0", count); n_err++; end
        n_cmp++;
        drain_en = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_addr  = 5'd0;
        in_data  = 32'h1234;
        #1;
        if (in_ready !== 1'b1) begin $display("FAIL zero_in_ready: got %0b want 1", in_ready); n_err++; end
        n_cmp++;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (wrEn !== 1'b0) begin $display("FAIL zero_wrEn[%0d]: got %0b want 0", i, wrEn); n_err++; end
            n_cmp++;
            if (count !== 3'd0) begin $display("FAIL zero_count[%0d]: got %0d want 0", i, count); n_err++; end
            n_cmp++;
            tick();
        end
        drain_en = 1'b0;
    endtask

    task automatic test_fwd();
        logic        exp_hit;
        logic [31:0] exp_data;
        exp_hit  = BYP;
        exp_data = BYP ? 32'h22 : 32'h0;
        drain_en = 1'b0;
        ra_addr  = 5'd7;
        rb_addr  = 5'd3;
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        #1;
        if (fwd_a_hit !== exp_hit) begin $display("FAIL fwd_a_hit_q: got %0b want %0b", fwd_a_hit, exp_hit); n_err++; end
        n_cmp++;
        if (fwd_a !== exp_data) begin $display("FAIL fwd_a_newest: got %h want %h", fwd_a, exp_data); n_err++; end
        n_cmp++;
        if (fwd_b_hit !== 1'b0) begin $display("FAIL fwd_b_nomatch: got %0b want 0", fwd_b_hit); n_err++; end
        n_cmp++;
        if (fwd_b !== 32'd0) begin $display("FAIL fwd_b_data: got %h want 0", fwd_b); n_err++; end
        n_cmp++;
        drain_en = 1'b1;
        #1;
        if (wd !== 32'h11) begin $display("FAIL fwd_order_first: got %h want 11", wd); n_err++; end
        n_cmp++;
        tick();
        #1;
        if (wd !== 32'h22) begin $display("FAIL fwd_order_second: got %h want 22", wd); n_err++; end
        n_cmp++;
        if (fwd_a_hit !== exp_hit) begin $display("FAIL fwd_head_pop_hit: got %0b want %0b", fwd_a_hit, exp_hit); n_err++; end
        n_cmp++;
        if (fwd_a !== exp_data) begin $display("FAIL fwd_head_pop_data: got %h want %h", fwd_a, exp_data); n_err++; end
        n_cmp++;
        tick();
        #1;
        if (fwd_a_hit !== 1'b0) begin $display("FAIL fwd_drained_hit: got %0b want 0", fwd_a_hit); n_err++; end
        n_cmp++;
        if (fwd_a !== 32'd0) begin $display("FAIL fwd_drained_data: got %h want 0", fwd_a); n_err++; end
        n_cmp++;
        drain_en = 1'b0;
        ra_addr  = 5'd0;
        rb_addr  = 5'd0;
        tick();
    endtask

    task automatic test_reset_mid();
        drain_en = 1'b0;
        push(5'd9,  32'h99);
        push(5'd10, 32'hAA);
        push(5'd11, 32'hBB);
        #1;
        if (count !== 3'd3) begin $display("FAIL rmid_count3: got %0d want 3", count); n_err++; end
        n_cmp++;
        reset    = 1'b1;
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_addr  = 5'd12;
        in_data  = 32'hCC;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        if (count !== 3'd0) begin $display("FAIL rmid_count0: got %0d want 0", count); n_err++; end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            if (wrEn !== 1'b0) begin $display("FAIL rmid_no_write[%0d]: got %0b want 0 (addr %0d)", i, wrEn, wd_addr); n_err++; end
            n_cmp++;
            tick();
            #1;
        end
        drain_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        drain_en = 1'b0;
        push(5'd1, 32'h101);
        push(5'd2, 32'h102);
        in_valid = 1'b1;
        in_addr  = 5'd3;
        in_data  = 32'h103;
        drain_en = 1'b1;
        #1;
        if (wrEn !== 1'b1) begin $display("FAIL b2b_wrEn: got %0b want 1", wrEn); n_err++; end
        n_cmp++;
        if (wd_addr !== 5'd1) begin $display("FAIL b2b_first: got %0d want 1", wd_addr); n_err++; end
        n_cmp++;
        if (in_ready !== 1'b1) begin $display("FAIL b2b_in_ready: got %0b want 1", in_ready); n_err++; end
        n_cmp++;
        tick();
        in_valid = 1'b0;
        #1;
        if (count !== 3'd2) begin $display("FAIL b2b_count: got %0d want 2", count); n_err++; end
        n_cmp++;
        if (wd_addr !== 5'd2 || wd !== 32'h102) begin $display("FAIL b2b_second: got %0d/%h want 2/102", wd_addr, wd); n_err++; end
        n_cmp++;
        tick();
        #1;
        if (wd_addr !== 5'd3 || wd !== 32'h103) begin $display("FAIL b2b_third: got %0d/%h want 3/103", wd_addr, wd); n_err++; end
        n_cmp++;
        tick();
        #1;
        if (count !== 3'd0) begin $display("FAIL b2b_empty: got %0d want 0", count); n_err++; end
        n_cmp++;
        drain_en = 1'b0;
    endtask

    initial begin
        wb_entry_t unused_entry;
        unused_entry = '0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = unused_entry.addr;
        in_data  = unused_entry.data;
        drain_en = 1'b0;
        ra_addr  = 5'd0;
        rb_addr  = 5'd0;
        test_reset();
        test_single();
        test_fill();
        test_zero();
        test_fwd();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
